// File: rtl/alpharetz_fifo_pkg.sv
// ---------------------------------------------------------------------------
// alpharetz_fifo_pkg
// Shared definitions for the UART-datapath FIFO family.
//   fifo_ptr_w(depth)    : index width needed to address 'depth' entries
//   fifo_depth_ok(depth) : 1 when depth is a power of two and at least 2
//   fifo_mode_e          : read-side behaviour (registered or fall-through)
// ---------------------------------------------------------------------------
package alpharetz_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Pointer arithmetic relies on natural wrap, so only powers of two work.
  function automatic bit fifo_depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// ---------------------------------------------------------------------------
// fifo_regfile
// DEPTH x DATA_WIDTH flop array: one synchronous write port, one
// asynchronous (combinational) read port, no reset.
//   clk      : rising-edge clock
//   wr_en    : write strobe
//   wr_addr  : write index
//   wr_data  : write data
//   rd_addr  : read index
//   rd_data  : read data, combinational from the array
// ---------------------------------------------------------------------------
module fifo_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset branch; contents are only observable
  // through the occupancy pointers, and leaving it out keeps it plain flops
  // without a reset net fanning out to every bit.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_queue_lvl.sv
// ---------------------------------------------------------------------------
// fifo_queue_lvl
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// synchronous flush and optional first-word-fall-through read mode.
//   clk, async_rst_n : clock; asynchronous active-low reset
//   clk_en           : qualifies every state update
//   flush            : clears contents (wins over wr_en/rd_en)
//   wr_en, data_in   : write request and data
//   rd_en            : read request (FWFT: pop head)
//   data_out         : read data (STD: registered; FWFT: current head)
//   rd_valid         : STD: data_out new this cycle; FWFT: !empty
//   full, empty      : occupancy flags
//   level            : entry count 0..DEPTH
//   afull_thresh     : almost_full  = level >= afull_thresh
//   aempty_thresh    : almost_empty = level <= aempty_thresh
// Build option ALPHARETZ_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// flags and their err_clr input.
// ---------------------------------------------------------------------------
module fifo_queue_lvl
  import alpharetz_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  parameter  bit FWFT       = 1'b0,
  localparam int PTR_WIDTH  = fifo_ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    level,
  input  logic [PTR_WIDTH:0]    afull_thresh,
  input  logic [PTR_WIDTH:0]    aempty_thresh,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef ALPHARETZ_FIFO_ERR_FLAGS_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam fifo_mode_e       MODE    = FWFT ? FIFO_FWFT : FIFO_STD;
  localparam bit               DEPTH_OK = fifo_depth_ok(DEPTH);
  localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // with every entry in use.
  logic [PTR_WIDTH:0]    wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head_data;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                 (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

  // Flags are pre-edge values, so a write while full is dropped even when a
  // read frees a slot on the same edge (and vice versa for empty).
  assign wr_acc = clk_en & wr_en & ~full  & ~flush;
  assign rd_acc = clk_en & rd_en & ~empty & ~flush;

  assign almost_full  = (level >= afull_thresh);
  assign almost_empty = (level <= aempty_thresh);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clk_en) begin
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_WIDTH)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[PTR_WIDTH-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[PTR_WIDTH-1:0]),
    .rd_data (head_data)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Head is masked while empty so reset and post-flush output is zero
      // rather than stale storage contents.
      assign data_out = empty ? '0 : head_data;
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (clk_en) begin
          valid_q <= rd_acc;
          if (rd_acc) data_q <= head_data;
        end
      end

      assign data_out = data_q;
      assign rd_valid = valid_q;
    end
  endgenerate

`ifdef ALPHARETZ_FIFO_ERR_FLAGS_EN
  logic ovf_set, udf_set;

  assign ovf_set = clk_en & wr_en & full  & ~flush;
  assign udf_set = clk_en & rd_en & empty & ~flush;

  // Set has priority over clear so an error on the clearing cycle survives.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clk_en) begin
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end
`endif

  depth_legal_a : assert property (@(posedge clk) DEPTH_OK)
    else $error("fifo_queue_lvl: DEPTH must be a power of two and >= 2");

endmodule

// File: tb/tb_fifo_queue_lvl.sv
// ---------------------------------------------------------------------------
// tb_fifo_queue_lvl
// Bench for fifo_queue_lvl with DATA_WIDTH=8, DEPTH=8. One instance in
// registered-read mode, one in first-word-fall-through mode.
// ---------------------------------------------------------------------------
module tb_fifo_queue_lvl;

  localparam int DW = 8;
  localparam int DP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // registered-read instance
  logic       s_clk_en = 0, s_flush = 0, s_wr = 0, s_rd = 0, s_err_clr = 0;
  logic [7:0] s_din = '0, s_dout;
  logic       s_rdv, s_full, s_empty, s_af, s_ae;
  logic [3:0] s_level;
  logic       s_ovf, s_udf;

  // fall-through instance
  logic       f_clk_en = 0, f_flush = 0, f_wr = 0, f_rd = 0, f_err_clr = 0;
  logic [7:0] f_din = '0, f_dout;
  logic       f_rdv, f_full, f_empty, f_af, f_ae;
  logic [3:0] f_level;
  logic       f_ovf, f_udf;

  logic [3:0] afull_th  = 4'd6;
  logic [3:0] aempty_th = 4'd2;

  fifo_queue_lvl #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1'b0)) dut_std (
    .clk (clk), .async_rst_n (rst_n), .clk_en (s_clk_en), .flush (s_flush),
    .wr_en (s_wr), .data_in (s_din), .rd_en (s_rd), .data_out (s_dout),
    .rd_valid (s_rdv), .full (s_full), .empty (s_empty), .level (s_level),
    .afull_thresh (afull_th), .aempty_thresh (aempty_th),
    .almost_full (s_af), .almost_empty (s_ae)
`ifdef ALPHARETZ_FIFO_ERR_FLAGS_EN
    , .err_clr (s_err_clr), .overflow (s_ovf), .underflow (s_udf)
`endif
  );

  fifo_queue_lvl #(.DATA_WIDTH(DW), .DEPTH(DP), .FWFT(1'b1)) dut_fwft (
    .clk (clk), .async_rst_n (rst_n), .clk_en (f_clk_en), .flush (f_flush),
    .wr_en (f_wr), .data_in (f_din), .rd_en (f_rd), .data_out (f_dout),
    .rd_valid (f_rdv), .full (f_full), .empty (f_empty), .level (f_level),
    .afull_thresh (afull_th), .aempty_thresh (aempty_th),
    .almost_full (f_af), .almost_empty (f_ae)
`ifdef ALPHARETZ_FIFO_ERR_FLAGS_EN
    , .err_clr (f_err_clr), .overflow (f_ovf), .underflow (f_udf)
`endif
  );

`ifndef ALPHARETZ_FIFO_ERR_FLAGS_EN
  assign s_ovf = 1'b0;
  assign s_udf = 1'b0;
  assign f_ovf = 1'b0;
  assign f_udf = 1'b0;
`endif

  typedef struct {
    logic       clk_en, flush, wr_en, rd_en;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic       exp_rdv;
    logic [3:0] exp_level;
    logic       exp_full, exp_empty, exp_af, exp_ae;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic ce, fl, wr, rd, input logic [7:0] din,
                              input logic [7:0] dout, input logic rdv,
                              input int lvl);
    vec_t v;
    v.clk_en = ce; v.flush = fl; v.wr_en = wr; v.rd_en = rd; v.din = din;
    v.exp_dout = dout; v.exp_rdv = rdv; v.exp_level = 4'(lvl);
    v.exp_full  = (lvl == 8);
    v.exp_empty = (lvl == 0);
    v.exp_af    = (lvl >= 6);
    v.exp_ae    = (lvl <= 2);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_drive(input logic ce, fl, wr, rd, input logic [7:0] din);
    s_clk_en = ce; s_flush = fl; s_wr = wr; s_rd = rd; s_din = din;
  endtask

  task automatic f_drive(input logic ce, fl, wr, rd, input logic [7:0] din);
    f_clk_en = ce; f_flush = fl; f_wr = wr; f_rd = rd; f_din = din;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_head;

    // Writes 0x01..0x08, a dropped 9th write, eight reads, a gated cycle
    // (rd_valid must hold), then a read while empty.
    for (int i = 0; i < 8; i++) tbl[i] = mk(1, 0, 1, 0, 8'(i + 1), 8'h00, 0, i + 1);
    tbl[8] = mk(1, 0, 1, 0, 8'hAA, 8'h00, 0, 8);
    for (int k = 0; k < 8; k++) tbl[9 + k] = mk(1, 0, 0, 1, 8'h00, 8'(k + 1), 1, 7 - k);
    tbl[17] = mk(0, 0, 1, 1, 8'h55, 8'h08, 1, 0);
    tbl[18] = mk(1, 0, 0, 1, 8'h00, 8'h08, 0, 0);

    #12;
    // reset state
    check("rst_std_level", 32'(s_level), 0);
    check("rst_std_empty", 32'(s_empty), 1);
    check("rst_std_full",  32'(s_full),  0);
    check("rst_std_dout",  32'(s_dout),  0);
    check("rst_std_rdv",   32'(s_rdv),   0);
    check("rst_fw_rdv",    32'(f_rdv),   0);
    check("rst_fw_dout",   32'(f_dout),  0);
    check("rst_ovf",       32'(s_ovf),   0);
    rst_n = 1'b1;
    step();

    // ---- FWFT: write into empty, visible next cycle, then pop ----
    f_drive(1, 0, 1, 0, 8'h5A);
    step();
    check("fw_5a_dout",  32'(f_dout),  32'h5A);
    check("fw_5a_rdv",   32'(f_rdv),   1);
    check("fw_5a_level", 32'(f_level), 1);
    f_drive(1, 0, 0, 1, 8'h00);
    step();
    check("fw_pop_empty", 32'(f_empty), 1);
    check("fw_pop_rdv",   32'(f_rdv),   0);
    f_drive(1, 0, 1, 0, 8'h11);
    step();
    f_drive(1, 0, 1, 0, 8'h22);
    step();
    check("fw_head_11", 32'(f_dout), 32'h11);
    f_drive(1, 0, 0, 1, 8'h00);
    step();
    check("fw_head_22",  32'(f_dout),  32'h22);
    check("fw_lvl_1",    32'(f_level), 1);
    f_drive(0, 0, 0, 0, 8'h00);

    // ---- registered mode: table ----
    for (int i = 0; i < 19; i++) begin
      s_drive(tbl[i].clk_en, tbl[i].flush, tbl[i].wr_en, tbl[i].rd_en, tbl[i].din);
      step();
      check($sformatf("v%0d_dout", i),  32'(s_dout),  32'(tbl[i].exp_dout));
      check($sformatf("v%0d_rdv", i),   32'(s_rdv),   32'(tbl[i].exp_rdv));
      check($sformatf("v%0d_level", i), 32'(s_level), 32'(tbl[i].exp_level));
      check($sformatf("v%0d_full", i),  32'(s_full),  32'(tbl[i].exp_full));
      check($sformatf("v%0d_empty", i), 32'(s_empty), 32'(tbl[i].exp_empty));
      check($sformatf("v%0d_af", i),    32'(s_af),    32'(tbl[i].exp_af));
      check($sformatf("v%0d_ae", i),    32'(s_ae),    32'(tbl[i].exp_ae));
    end

`ifdef ALPHARETZ_FIFO_ERR_FLAGS_EN
    check("err_ovf_sticky", 32'(s_ovf), 1);
    check("err_udf_sticky", 32'(s_udf), 1);
    s_drive(1, 0, 0, 0, 8'h00);
    s_err_clr = 1'b1;
    step();
    s_err_clr = 1'b0;
    check("err_ovf_clr", 32'(s_ovf), 0);
    check("err_udf_clr", 32'(s_udf), 0);
`endif

    // ---- level 4, simultaneous read/write across pointer wrap ----
    for (int i = 0; i < 4; i++) begin
      s_drive(1, 0, 1, 0, 8'(8'h10 + i));
      q.push_back(8'(8'h10 + i));
      step();
    end
    check("wrap_pre_level", 32'(s_level), 4);
    for (int i = 0; i < 20; i++) begin
      s_drive(1, 0, 1, 1, 8'(8'h20 + i));
      exp_head = q.pop_front();
      q.push_back(8'(8'h20 + i));
      step();
      check($sformatf("wrap%0d_dout", i),  32'(s_dout),  32'(exp_head));
      check($sformatf("wrap%0d_level", i), 32'(s_level), 4);
      check($sformatf("wrap%0d_rdv", i),   32'(s_rdv),   1);
    end

    // ---- flush at level 5 beats a same-cycle write ----
    s_drive(1, 0, 1, 0, 8'h99);
    step();
    check("flush_pre_level", 32'(s_level), 5);
    s_drive(1, 1, 1, 0, 8'hEE);
    step();
    check("flush_level", 32'(s_level), 0);
    check("flush_empty", 32'(s_empty), 1);
    check("flush_rdv",   32'(s_rdv),   0);

    // Refill to 4, then clk_en=0 with wr_en held must not move the level.
    for (int i = 0; i < 4; i++) begin
      s_drive(1, 0, 1, 0, 8'(8'h31 + i));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      s_drive(0, 0, 1, 0, 8'hCC);
      step();
      check($sformatf("gate%0d_level", i), 32'(s_level), 4);
    end
    s_drive(1, 0, 0, 1, 8'h00);
    step();
    check("post_flush_head", 32'(s_dout),  32'h31);
    check("post_flush_lvl",  32'(s_level), 3);
    s_drive(0, 0, 0, 0, 8'h00);

    // ---- asynchronous reset between edges at level 3 ----
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_level", 32'(s_level), 0);
    check("arst_empty", 32'(s_empty), 1);
    check("arst_dout",  32'(s_dout),  0);
    check("arst_rdv",   32'(s_rdv),   0);
    check("arst_fw_lvl", 32'(f_level), 0);
    #1;
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
